// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : video_pkg
//  Brief   : Shared pixel types, defaults and colour helpers for the video
//            output path.
//  Rev     : 1.0  initial release
// ============================================================================
package video_pkg;

    localparam int PIXELS_PER_WORD_DEFAULT = 4;

    typedef logic [15:0] rgb555_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    // Replicate the channel MSBs into the new LSBs so full-scale 5-bit maps
    // to full-scale 8-bit; bit 15 carries no colour.
    function automatic rgb888_t rgb555_to_888(input rgb555_t p);
        rgb888_t c;
        c.r = {p[14:10], p[14:12]};
        c.g = {p[9:5],   p[9:7]};
        c.b = {p[4:0],   p[4:2]};
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_pixel_unpacker.sv
`default_nettype none
// ============================================================================
//  Module  : video_pixel_unpacker
//  Brief   : Locks onto the output video FIFO during blanking, serialises
//            each FIFO word into RGB555 pixels (LSB pixel first), expands
//            them to RGB888 and registers them with delayed sync/enable.
//            Underflow drops lock and is counted with saturation.
//  Rev     : 1.0  initial release
// ============================================================================
module video_pixel_unpacker
    import video_pkg::*;
#(
    parameter int PIXELS_PER_WORD = PIXELS_PER_WORD_DEFAULT,
    parameter int UNDERFLOW_W     = 16
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [16*PIXELS_PER_WORD-1:0] fifo_q,
    input  logic                         fifo_empty,
    output logic                         fifo_rdreq,
    input  logic                         video_enable,
    input  logic                         hblank,
    input  logic                         vblank,
    input  logic                         hsync,
    input  logic                         vsync,
    input  logic                         resync,
    output logic [7:0]                   vga_r,
    output logic [7:0]                   vga_g,
    output logic [7:0]                   vga_b,
    output logic                         vga_de,
    output logic                         vga_hs,
    output logic                         vga_vs,
    output logic                         locked,
    output logic [UNDERFLOW_W-1:0]       underflow_count
);

    localparam int                IDX_W    = (PIXELS_PER_WORD > 1) ? $clog2(PIXELS_PER_WORD) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PIXELS_PER_WORD - 1);
    localparam logic [UNDERFLOW_W-1:0] CNT_MAX = {UNDERFLOW_W{1'b1}};

    lock_state_e             state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [UNDERFLOW_W-1:0]  ufl_cnt_q, ufl_cnt_d;
    rgb888_t                 rgb_q, rgb_d;
    logic                    de_q, hs_q, vs_q;

    logic                    is_locked_w;
    logic                    consume_w;
    logic                    underflow_w;
    logic                    last_w;
    logic                    lock_cond_w;
    rgb555_t                 pix_w;

    assign is_locked_w = (state_q == LOCKED);
    assign consume_w   = is_locked_w & video_enable & ~fifo_empty;
    assign underflow_w = is_locked_w & video_enable &  fifo_empty;
    assign last_w      = (idx_q == LAST_IDX);
    assign lock_cond_w = hblank & vblank & ~fifo_empty & ~resync;

    // Pixel idx occupies bits [16*idx +: 16]; pixel 0 is least significant.
    assign pix_w = fifo_q[{idx_q, 4'b0000} +: 16];

    // Pop only when the final pixel of the head word is shown; resync
    // suppresses the pop so the word is replayed from pixel 0 after relock.
    assign fifo_rdreq = consume_w & last_w & ~resync;

    // Next-state for lock FSM, pixel index and underflow counter; resync wins.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ufl_cnt_d = ufl_cnt_q;
        if (resync) begin
            state_d = UNLOCKED;
            idx_d   = '0;
        end else begin
            case (state_q)
                UNLOCKED: begin
                    if (lock_cond_w) begin
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (underflow_w) begin
                        state_d = UNLOCKED;
                        idx_d   = '0;
                        if (ufl_cnt_q != CNT_MAX) begin
                            ufl_cnt_d = ufl_cnt_q + 1'b1;
                        end
                    end else if (consume_w) begin
                        idx_d = last_w ? '0 : idx_q + 1'b1;
                    end
                end
                default: begin
                    state_d = UNLOCKED;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Pixel colour for this cycle; black unless a pixel is actually consumed.
    always_comb begin
        rgb_d = '0;
        if (consume_w) begin
            rgb_d = rgb555_to_888(pix_w);
        end
    end

    // State, index, counter and output register stage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= UNLOCKED;
            idx_q     <= '0;
            ufl_cnt_q <= '0;
            rgb_q     <= '0;
            de_q      <= 1'b0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ufl_cnt_q <= ufl_cnt_d;
            rgb_q     <= rgb_d;
            de_q      <= video_enable;
            hs_q      <= hsync;
            vs_q      <= vsync;
        end
    end

    assign vga_r           = rgb_q.r;
    assign vga_g           = rgb_q.g;
    assign vga_b           = rgb_q.b;
    assign vga_de          = de_q;
    assign vga_hs          = hs_q;
    assign vga_vs          = vs_q;
    assign locked          = is_locked_w;
    assign underflow_count = ufl_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_video_pixel_unpacker.sv
`default_nettype none
// ============================================================================
//  Module  : tb_video_pixel_unpacker
//  Brief   : Directed self-checking bench for video_pixel_unpacker.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_video_pixel_unpacker;

    localparam int PPW   = 4;
    localparam int UFL_W = 4;

    logic              clock;
    logic              reset_n;
    logic [16*PPW-1:0] fifo_q;
    logic              fifo_empty;
    logic              fifo_rdreq;
    logic              video_enable;
    logic              hblank, vblank, hsync, vsync, resync;
    logic [7:0]        vga_r, vga_g, vga_b;
    logic              vga_de, vga_hs, vga_vs;
    logic              locked;
    logic [UFL_W-1:0]  underflow_count;

    int errors = 0;
    int checks = 0;

    video_pixel_unpacker #(
        .PIXELS_PER_WORD (PPW),
        .UNDERFLOW_W     (UFL_W)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .fifo_q          (fifo_q),
        .fifo_empty      (fifo_empty),
        .fifo_rdreq      (fifo_rdreq),
        .video_enable    (video_enable),
        .hblank          (hblank),
        .vblank          (vblank),
        .hsync           (hsync),
        .vsync           (vsync),
        .resync          (resync),
        .vga_r           (vga_r),
        .vga_g           (vga_g),
        .vga_b           (vga_b),
        .vga_de          (vga_de),
        .vga_hs          (vga_hs),
        .vga_vs          (vga_vs),
        .locked          (locked),
        .underflow_count (underflow_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs shortly after a rising edge.
    task automatic drive(input logic ve, input logic hb, input logic vb,
                         input logic hs, input logic vs, input logic empty,
                         input logic rs);
        video_enable = ve;
        hblank       = hb;
        vblank       = vb;
        hsync        = hs;
        vsync        = vs;
        fifo_empty   = empty;
        resync       = rs;
        #1;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] rgb_now();
        return {8'h00, vga_r, vga_g, vga_b};
    endfunction

    logic [23:0] exp_rgb [4];
    logic [2:0]  hv_pat  [6];

    initial begin
        exp_rgb[0] = 24'hFF0000;
        exp_rgb[1] = 24'h00FF00;
        exp_rgb[2] = 24'h0000FF;
        exp_rgb[3] = 24'hFFFFFF;
        hv_pat[0] = 3'b101; hv_pat[1] = 3'b010; hv_pat[2] = 3'b111;
        hv_pat[3] = 3'b000; hv_pat[4] = 3'b100; hv_pat[5] = 3'b011;

        // ---------------- reset with busy inputs ----------------
        reset_n = 1'b0;
        fifo_q  = 64'h7FFF_001F_03E0_7C00;
        drive(1, 1, 1, 1, 1, 0, 0);
        repeat (3) cyc();
        chk("reset_rgb",    rgb_now(), 32'h0);
        chk("reset_de",     {31'd0, vga_de}, 32'd0);
        chk("reset_hsvs",   {30'd0, vga_hs, vga_vs}, 32'd0);
        chk("reset_locked", {31'd0, locked}, 32'd0);
        chk("reset_count",  {28'd0, underflow_count}, 32'd0);
        chk("reset_rdreq",  {31'd0, fifo_rdreq}, 32'd0);

        // ---------------- release mid-line: no lock, no pop ----------------
        drive(1, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        repeat (5) begin
            cyc();
            chk("midline_rdreq", {31'd0, fifo_rdreq}, 32'd0);
        end
        chk("midline_locked", {31'd0, locked}, 32'd0);
        chk("midline_black",  rgb_now(), 32'h0);
        chk("midline_de",     {31'd0, vga_de}, 32'd1);

        // ---------------- blanking with empty FIFO: no lock ----------------
        drive(0, 1, 1, 0, 0, 1, 0);
        cyc();
        chk("nolock_empty", {31'd0, locked}, 32'd0);

        // ---------------- lock and serialise one word ----------------
        drive(0, 1, 1, 0, 0, 0, 0);
        cyc();
        chk("lock_rise", {31'd0, locked}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0);
            chk($sformatf("ser_rdreq%0d", i), {31'd0, fifo_rdreq}, (i == 3) ? 32'd1 : 32'd0);
            cyc();
            chk($sformatf("ser_rgb%0d", i), rgb_now(), {8'h00, exp_rgb[i]});
            chk($sformatf("ser_de%0d", i), {31'd0, vga_de}, 32'd1);
        end

        // ---------------- inactive video: black, lock held ----------------
        drive(0, 0, 0, 0, 0, 0, 0);
        cyc();
        chk("idle_black",  rgb_now(), 32'h0);
        chk("idle_de",     {31'd0, vga_de}, 32'd0);
        chk("idle_locked", {31'd0, locked}, 32'd1);

        // ---------------- underflow ----------------
        drive(1, 0, 0, 0, 0, 1, 0);
        chk("ufl_rdreq", {31'd0, fifo_rdreq}, 32'd0);
        cyc();
        chk("ufl_black",  rgb_now(), 32'h0);
        chk("ufl_count",  {28'd0, underflow_count}, 32'd1);
        chk("ufl_unlock", {31'd0, locked}, 32'd0);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("ufl_nopop", {31'd0, fifo_rdreq}, 32'd0);
        cyc();
        chk("ufl_stay_unlocked", {31'd0, locked}, 32'd0);
        chk("ufl_stay_black",    rgb_now(), 32'h0);

        // ---------------- resync mid-word ----------------
        fifo_q = 64'h0000_7FFF_03E0_001F;
        drive(0, 1, 1, 0, 0, 0, 0);
        cyc();
        chk("relock", {31'd0, locked}, 32'd1);
        drive(1, 0, 0, 0, 0, 0, 0); cyc();
        chk("rs_pix0", rgb_now(), 32'h0000FF);
        drive(1, 0, 0, 0, 0, 0, 0); cyc();
        chk("rs_pix1", rgb_now(), 32'h00FF00);
        drive(1, 0, 0, 0, 0, 0, 1);
        chk("rs_rdreq_idx2", {31'd0, fifo_rdreq}, 32'd0);
        cyc();
        chk("rs_pix2_out", rgb_now(), 32'hFFFFFF);
        chk("rs_unlock",   {31'd0, locked}, 32'd0);
        chk("rs_count",    {28'd0, underflow_count}, 32'd1);

        // resync blocks a lock condition
        drive(0, 1, 1, 0, 0, 0, 1);
        cyc();
        chk("rs_blocks_lock", {31'd0, locked}, 32'd0);
        drive(0, 1, 1, 0, 0, 0, 0);
        cyc();
        chk("relock2", {31'd0, locked}, 32'd1);
        drive(1, 0, 0, 0, 0, 0, 0); cyc();
        chk("replay_pix0", rgb_now(), 32'h0000FF);
        drive(1, 0, 0, 0, 0, 0, 0); cyc();
        drive(1, 0, 0, 0, 0, 0, 0); cyc();
        chk("replay_pix2", rgb_now(), 32'hFFFFFF);
        // resync on the last pixel suppresses the pop
        drive(1, 0, 0, 0, 0, 0, 1);
        chk("rs_rdreq_idx3", {31'd0, fifo_rdreq}, 32'd0);
        cyc();
        chk("rs_pix3_out", rgb_now(), 32'h0);

        // resync together with underflow: no count
        drive(0, 1, 1, 0, 0, 0, 0); cyc();
        drive(1, 0, 0, 0, 0, 1, 1); cyc();
        chk("rs_ufl_count",  {28'd0, underflow_count}, 32'd1);
        chk("rs_ufl_locked", {31'd0, locked}, 32'd0);

        // ---------------- saturation: 2^UFL_W+3 underflows ----------------
        for (int n = 0; n < (1 << UFL_W) + 3; n++) begin
            drive(0, 1, 1, 0, 0, 0, 0); cyc();
            drive(1, 0, 0, 0, 0, 1, 0); cyc();
            if (n == 13) chk("sat_reach_max", {28'd0, underflow_count}, 32'd15);
        end
        chk("sat_hold", {28'd0, underflow_count}, 32'd15);

        // ---------------- sync / enable alignment ----------------
        for (int k = 0; k < 6; k++) begin
            drive(hv_pat[k][2], 0, 0, hv_pat[k][1], hv_pat[k][0], 1, 0);
            cyc();
            chk($sformatf("align%0d", k), {29'd0, vga_de, vga_hs, vga_vs}, {29'd0, hv_pat[k]});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
